// File: rtl/yalu_pkg.sv
// Shared definitions for the y_alu_pipe ALU: op encodings and control FSM states.
package yalu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {
    IDLE,
    BUSY
  } alu_state_e;

endpackage

// File: rtl/y_mul_iter.sv
// Iterative shift-and-add multiplier: W iterations after start, low W bits of a*b.
// done is a one-cycle pulse during the last iteration; p is valid only while done is high,
// so the consumer can register the product on the same edge the last iteration completes.
module y_mul_iter
  import yalu_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     acc_next;
  logic             last;

  // Partial-product accumulate for the current multiplier bit and last-iteration detect.
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    last     = busy_q && (cnt_q == CNT_W'(W - 1));
  end

  // Next-state: latch operands on start, otherwise shift one bit per cycle while busy.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // State registers with synchronous reset; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done = last;
  assign p    = acc_next;

endmodule

// File: rtl/y_alu_pipe.sv
// Registered ALU with valid/ready on both sides. Single-cycle AND/OR/ADD/SUB/SLT,
// W-cycle iterative MUL. Optional signed-overflow output enabled by YALU_OVF_EN.
module y_alu_pipe
  import yalu_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         zero,
  output logic         err
`ifdef YALU_OVF_EN
  ,
  output logic         ovf
`endif
);

  alu_state_e   state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] z_q, z_d;
  logic         zero_q, zero_d;
  logic         err_q, err_d;

  logic         accept;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] mul_p;
  logic         load_alu;
  logic         load_mul;

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         slt;
  logic [W-1:0] res;
  logic         illegal;

`ifdef YALU_OVF_EN
  logic ovf_c;
  logic ovf_q, ovf_d;
`endif

  // Handshake: accept only in IDLE and only when the output slot is free or draining.
  always_comb begin
    in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    mul_start = accept && (op == OP_MUL);
  end

  y_mul_iter #(
    .W    (W),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(mul_start),
    .a    (a),
    .b    (b),
    .done (mul_done),
    .p    (mul_p)
  );

  // Single-cycle datapath; SLT uses the subtract sign unless operand signs differ.
  always_comb begin
    sum     = a + b;
    diff    = a + ~b + W'(1);
    slt     = (a[W-1] == b[W-1]) ? diff[W-1] : a[W-1];
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = sum;
      OP_SUB:  res = diff;
      OP_SLT:  res = {{(W - 1){1'b0}}, slt};
      OP_MUL:  res = '0;
      default: illegal = 1'b1;
    endcase
  end

`ifdef YALU_OVF_EN
  // Signed overflow: ADD when equal-sign operands flip sign, SUB when differing signs do.
  always_comb begin
    ovf_c = 1'b0;
    if (op == OP_ADD) begin
      ovf_c = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end else if (op == OP_SUB) begin
      ovf_c = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    end
  end
`endif

  // FSM next-state and output-register load; a new result may replace one being consumed.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    zero_d      = zero_q;
    err_d       = err_q;
`ifdef YALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    load_alu    = accept && (op != OP_MUL);
    load_mul    = (state_q == BUSY) && mul_done;

    unique case (state_q)
      IDLE:    if (mul_start) state_d = BUSY;
      BUSY:    if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_alu) begin
      z_d    = res;
      zero_d = (res == '0);
      err_d  = illegal;
`ifdef YALU_OVF_EN
      ovf_d  = ovf_c;
`endif
    end else if (load_mul) begin
      z_d    = mul_p;
      zero_d = (mul_p == '0);
      err_d  = 1'b0;
`ifdef YALU_OVF_EN
      ovf_d  = 1'b0;
`endif
    end

    if (load_alu || load_mul) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef YALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
`ifdef YALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign zero      = zero_q;
  assign err       = err_q;
`ifdef YALU_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_y_alu_pipe.sv
// Directed + scoreboard bench for y_alu_pipe (W=32). Optional ovf check under YALU_OVF_EN.
module tb_y_alu_pipe;
  import yalu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         zero;
  logic         err;
`ifdef YALU_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] z;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  y_alu_pipe #(
    .W    (W),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z        (z),
    .zero     (zero),
    .err      (err)
`ifdef YALU_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the op definitions rather than the RTL structure.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] prod;
    e = '0;
    case (o)
      3'b000: e.z = x & y;
      3'b001: e.z = x | y;
      3'b010: e.z = x + y;
      3'b110: e.z = x - y;
      3'b111: e.z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011: begin
        prod = {32'd0, x} * {32'd0, y};
        e.z  = prod[W-1:0];
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.z == '0);
    return e;
  endfunction

  // Compare a transfer happening at the upcoming edge against the scoreboard head.
  task automatic check_out();
    exp_t  e;
    string t;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_extra: observed output z=%0h with empty scoreboard, expected none", z);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_z"}, 64'(z), 64'(e.z));
        chk({t, "_zero"}, 64'(zero), 64'(e.zero));
        chk({t, "_err"}, 64'(err), 64'(e.err));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input exp_t e);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      check_out();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    assert (acc) else begin
      n_err++;
      $error("FAIL %s_accept: observed no accept in 200 cycles, expected accept", tag);
    end
    if (acc) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  // Waits for out_valid, counting cycles with in_ready low; consumes the result.
  task automatic wait_out(input string tag, output int busy);
    bit seen;
    seen = 1'b0;
    busy = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else if (!in_ready) busy++;
      check_out();
      @(posedge clk);
      #1;
    end
    n_cmp++;
    assert (seen) else begin
      n_err++;
      $error("FAIL %s_wait: observed no out_valid in 100 cycles, expected out_valid", tag);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain: observed %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    int           busy;
    bit           stray;
    logic [2:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   ops[8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single-cycle ops
    send("add", 3'b010, 32'd7, 32'd5, '{z: 32'd12, zero: 1'b0, err: 1'b0});
    chk("add_latency", 64'(out_valid), 64'd1);
    drain();
    send("sub", 3'b110, 32'd5, 32'd5, '{z: 32'd0, zero: 1'b1, err: 1'b0});
    send("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, '{z: 32'd1, zero: 1'b0, err: 1'b0});
    send("slt_pos", 3'b111, 32'd1, 32'hFFFF_FFFF, '{z: 32'd0, zero: 1'b1, err: 1'b0});
    send("illegal", 3'b100, 32'd9, 32'd3, '{z: 32'd0, zero: 1'b1, err: 1'b1});
    drain();

    // Iterative multiply: 32 busy cycles, then result
    send("mul", 3'b011, 32'd6, 32'd7, '{z: 32'd42, zero: 1'b0, err: 1'b0});
    wait_out("mul", busy);
    chk("mul_busy_cycles", 64'(busy), 64'd32);
    send("mul_wrap", 3'b011, 32'h0001_0000, 32'h0001_0000, '{z: 32'd0, zero: 1'b1, err: 1'b0});
    wait_out("mul_wrap", busy);
    drain();

    // Backpressure hold, then release with a queued op: no bubble
    out_ready = 1'b0;
    send("bp_add", 3'b010, 32'd1, 32'd1, '{z: 32'd2, zero: 1'b0, err: 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_z", 64'(z), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send("bp_and", 3'b000, 32'hF0, 32'h3C, '{z: 32'h30, zero: 1'b0, err: 1'b0});
    chk("bp_nobubble_valid", 64'(out_valid), 64'd1);
    chk("bp_nobubble_z", 64'(z), 64'h30);
    drain();

    // Reset part-way through a multiply aborts it
    send("mul_abort", 3'b011, 32'd3, 32'd3, '{z: 32'd9, zero: 1'b0, err: 1'b0});
    void'(exp_q.pop_back());
    void'(tag_q.pop_back());
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("abort_no_valid", 64'(stray), 64'd0);

    // Reset while a result is pending discards it
    out_ready = 1'b0;
    send("discard", 3'b010, 32'd2, 32'd3, '{z: 32'd5, zero: 1'b0, err: 1'b0});
    void'(exp_q.pop_back());
    void'(tag_q.pop_back());
    chk("discard_pending", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("discard_valid", 64'(out_valid), 64'd0);
    chk("discard_z", 64'(z), 64'd0);
    out_ready = 1'b1;

`ifdef YALU_OVF_EN
    send("ovf_add", 3'b010, 32'h7FFF_FFFF, 32'd1, '{z: 32'h8000_0000, zero: 1'b0, err: 1'b0});
    chk("ovf_add_flag", 64'(ovf), 64'd1);
    drain();
    send("ovf_sub", 3'b110, 32'd5, 32'd3, '{z: 32'd2, zero: 1'b0, err: 1'b0});
    chk("ovf_sub_flag", 64'(ovf), 64'd0);
    drain();
`endif

    // Randomised back-to-back traffic against the model
    for (int i = 0; i < 12; i++) begin
      o = ops[$urandom_range(0, 7)];
      x = $urandom();
      y = (i % 3 == 0) ? x : $urandom();
      send("rnd", o, x, y, model(o, x, y));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
